// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO window constants (default base, register offsets, window size).
package mmio_pkg;
    localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_0000;
    localparam int          WIN_SIZE      = 256;
    localparam logic [7:0]  OFF_VALUE     = 8'h80;
    localparam logic [7:0]  OFF_RISE      = 8'h84;
    localparam logic [7:0]  OFF_FALL      = 8'h88;
    localparam logic [7:0]  OFF_EN        = 8'h8C;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchroniser plus stability counter for one raw pin.
// Ports: i_clk clock, i_rst_n async active-low reset, i_pin raw async input, o_db debounced level.
module input_debouncer #(
    parameter int DB_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_db
);
    logic [1:0] r_sync;
    logic       r_db;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_sync <= '0;
        else          r_sync <= {r_sync[0], i_pin};
    generate
        if (DB_CYCLES == 0) begin : g_bypass
            always_ff @(posedge i_clk or negedge i_rst_n)
                if (!i_rst_n) r_db <= 1'b0;
                else          r_db <= r_sync[1];
        end else begin : g_count
            localparam int CW = $clog2(DB_CYCLES + 1);
            logic [CW-1:0] r_cnt;
            // Any cycle where the synchronised level matches db restarts the count,
            // so only an uninterrupted run of DB_CYCLES differing cycles commits.
            always_ff @(posedge i_clk or negedge i_rst_n)
                if (!i_rst_n) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (r_sync[1] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                    r_cnt <= '0;
                    r_db  <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
        end
    endgenerate
    assign o_db = r_db;
endmodule

// File: rtl/mmio_input_bank.sv
// mmio_input_bank: N debounced pins on the MMIO bus with value, edge-pending (W1C), edge-enable and irq.
// Ports: sys_clk/rst_n clock and async active-low reset; mmio_read/mmio_write/mmio_addr/mmio_write_data
// request side; mmio_work (combinational in-window request), mmio_done (one-cycle completion pulse),
// mmio_read_data (valid with done) response side; irq level interrupt; pins raw inputs.
module mmio_input_bank
    import mmio_pkg::*;
#(
    parameter int          N_PINS    = 24,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          DB_CYCLES = 100000
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              mmio_read,
    input  logic              mmio_write,
    input  logic [31:0]       mmio_addr,
    input  logic [31:0]       mmio_write_data,
    output logic              mmio_work,
    output logic              mmio_done,
    output logic [31:0]       mmio_read_data,
    output logic              irq,
    input  logic [N_PINS-1:0] pins
);
    logic [N_PINS-1:0] w_db, r_db_q, r_rise, r_fall, r_en;
    logic [N_PINS-1:0] w_clr_rise, w_clr_fall, w_set_rise, w_set_fall;
    logic [31:0]       w_db32, w_rd_mux, r_rdata;
    logic [7:0]        w_off;
    logic              w_in_win, w_acc, w_wr, r_done, r_irq, w_unused;

    genvar k;
    generate
        for (k = 0; k < N_PINS; k++) begin : g_pin
            input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db (
                .i_clk  (sys_clk),
                .i_rst_n(rst_n),
                .i_pin  (pins[k]),
                .o_db   (w_db[k])
            );
        end
    endgenerate

    // Unsigned difference wraps for addresses below the base, so one compare covers both ends.
    assign w_in_win  = (mmio_addr - BASE_ADDR) < 32'(WIN_SIZE);
    assign w_off     = mmio_addr[7:0];
    assign mmio_work = w_in_win & (mmio_read | mmio_write);
    assign w_acc     = mmio_work & ~r_done;
    assign w_wr      = w_acc & mmio_write;
    assign w_unused  = &{1'b0, mmio_addr[1:0], mmio_write_data};

    always_comb begin
        w_db32     = 32'(w_db);
        w_rd_mux   = !w_off[7]                     ? {31'b0, w_db32[w_off[6:2]]} :
                     (w_off[7:2] == OFF_VALUE[7:2]) ? w_db32 :
                     (w_off[7:2] == OFF_RISE[7:2])  ? 32'(r_rise) :
                     (w_off[7:2] == OFF_FALL[7:2])  ? 32'(r_fall) :
                     (w_off[7:2] == OFF_EN[7:2])    ? 32'(r_en) : 32'b0;
        w_clr_rise = (w_wr && w_off[7:2] == OFF_RISE[7:2]) ? mmio_write_data[N_PINS-1:0] : '0;
        w_clr_fall = (w_wr && w_off[7:2] == OFF_FALL[7:2]) ? mmio_write_data[N_PINS-1:0] : '0;
        w_set_rise = w_db & ~r_db_q & r_en;
        w_set_fall = ~w_db & r_db_q & r_en;
    end

    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            r_db_q  <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_en    <= '0;
            r_done  <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_db_q  <= w_db;
            // Set is ORed after the clear so a same-cycle edge survives the W1C.
            r_rise  <= (r_rise & ~w_clr_rise) | w_set_rise;
            r_fall  <= (r_fall & ~w_clr_fall) | w_set_fall;
            r_irq   <= |{r_rise, r_fall};
            if (w_wr && w_off[7:2] == OFF_EN[7:2]) r_en <= mmio_write_data[N_PINS-1:0];
            r_done  <= w_acc;
            r_rdata <= (w_acc && !mmio_write) ? w_rd_mux : 32'b0;
        end

    assign mmio_done      = r_done;
    assign mmio_read_data = r_rdata;
    assign irq            = r_irq;
endmodule

// File: tb/tb_mmio_input_bank.sv
// tb_mmio_input_bank: randomized self-checking bench against a behavioural model of the input bank.
module tb_mmio_input_bank;
    localparam int          N = 24;
    localparam int          D = 4;
    localparam logic [31:0] B = 32'hFFFF_0000;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mmio_read = 1'b0;
    logic          mmio_write = 1'b0;
    logic [31:0]   mmio_addr = '0;
    logic [31:0]   mmio_write_data = '0;
    logic          mmio_work, mmio_done, irq;
    logic [31:0]   mmio_read_data;
    logic [N-1:0]  pins = '0;

    int n_chk = 0;
    int n_err = 0;
    logic [N-1:0] m_db = '0, m_rise = '0, m_fall = '0, m_en = '0;

    mmio_input_bank #(.N_PINS(N), .BASE_ADDR(B), .DB_CYCLES(D)) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .mmio_read      (mmio_read),
        .mmio_write     (mmio_write),
        .mmio_addr      (mmio_addr),
        .mmio_write_data(mmio_write_data),
        .mmio_work      (mmio_work),
        .mmio_done      (mmio_done),
        .mmio_read_data (mmio_read_data),
        .irq            (irq),
        .pins           (pins)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic access(input logic wr, input logic [7:0] off, input logic [31:0] wd, output logic [31:0] rd);
        mmio_addr       = B | 32'(off);
        mmio_write_data = wd;
        mmio_read       = !wr;
        mmio_write      = wr;
        #1 chk("work", {31'b0, mmio_work}, 32'd1);
        for (int t = 0; t < 4; t++) begin
            @(posedge sys_clk);
            #1;
            if (mmio_done) break;
        end
        chk("done", {31'b0, mmio_done}, 32'd1);
        rd         = mmio_read_data;
        mmio_read  = 1'b0;
        mmio_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] r;
        access(1'b0, off, 32'b0, r);
        chk(tag, r, exp);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] r;
        access(1'b1, off, d, r);
    endtask

    task automatic check_all(input string tag);
        int          k;
        logic [31:0] e;
        rd_chk({tag, "_value"}, 8'h80, 32'(m_db));
        rd_chk({tag, "_rise"}, 8'h84, 32'(m_rise));
        rd_chk({tag, "_fall"}, 8'h88, 32'(m_fall));
        rd_chk({tag, "_en"}, 8'h8C, 32'(m_en));
        k = $urandom_range(0, 31);
        e = (k < N) ? {31'b0, m_db[k]} : 32'b0;
        rd_chk({tag, "_word"}, 8'(k * 4), e);
        chk({tag, "_irq"}, {31'b0, irq}, {31'b0, |(m_rise | m_fall)});
    endtask

    initial begin
        logic         seen;
        logic [N-1:0] nv, mask;
        int           op;

        edges(3);
        chk("rst_done", {31'b0, mmio_done}, 32'd0);
        chk("rst_rdata", mmio_read_data, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        edges(2);
        rd_chk("rst_value", 8'h80, 32'd0);
        chk("rst_irq2", {31'b0, irq}, 32'd0);

        mmio_addr = B + 32'h100;
        mmio_read = 1'b1;
        #1 chk("oow_work", {31'b0, mmio_work}, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            edges(1);
            seen |= mmio_done;
        end
        chk("oow_done", {31'b0, seen}, 32'd0);
        mmio_read = 1'b0;
        edges(2);

        pins = 24'hA5A5A5;
        edges(5);
        rd_chk("value_early", 8'h80, 32'd0);
        rd_chk("value_a5", 8'h80, 32'h00A5A5A5);
        m_db = 24'hA5A5A5;
        rd_chk("word_pin5", 8'h14, 32'd1);
        rd_chk("word_pin1", 8'h04, 32'd0);
        rd_chk("word_31", 8'h7C, 32'd0);
        rd_chk("rise_dis", 8'h84, 32'd0);
        pins = '0;
        m_db = '0;
        edges(D + 4);
        check_all("clear");

        wr(8'h8C, 32'h1);
        m_en = 24'h1;
        pins = 24'h1;
        edges(3);
        pins = '0;
        edges(D + 4);
        rd_chk("glitch_value", 8'h80, 32'd0);
        rd_chk("glitch_rise", 8'h84, 32'd0);

        edges(2);
        pins = 24'h1;
        edges(D + 3);
        chk("irq_before", {31'b0, irq}, 32'd0);
        edges(1);
        chk("irq_after", {31'b0, irq}, 32'd1);
        pins = '0;
        edges(D + 4);
        rd_chk("pend_rise", 8'h84, 32'd1);
        rd_chk("pend_fall", 8'h88, 32'd1);
        chk("irq_pend", {31'b0, irq}, 32'd1);
        wr(8'h84, 32'h1);
        wr(8'h88, 32'h1);
        edges(1);
        chk("irq_clr", {31'b0, irq}, 32'd0);
        rd_chk("clr_rise", 8'h84, 32'd0);
        rd_chk("clr_fall", 8'h88, 32'd0);

        edges(2);
        pins = 24'h1;
        edges(D + 2);
        wr(8'h84, 32'h1);
        rd_chk("set_wins", 8'h84, 32'd1);
        wr(8'h84, 32'h1);
        pins = '0;
        edges(D + 4);
        wr(8'h88, 32'h1);
        edges(1);
        check_all("after_race");

        wr(8'h8C, 32'hFFFF_FFFF);
        m_en = '1;
        rd_chk("en_mask", 8'h8C, 32'h00FF_FFFF);
        wr(8'h80, 32'h1234);
        edges(1);
        chk("done_once", {31'b0, mmio_done}, 32'd0);
        rd_chk("value_ro", 8'h80, 32'(m_db));
        wr(8'h90, 32'hFFFF_FFFF);
        rd_chk("reserved", 8'h90, 32'd0);

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 4);
            if (op <= 1) begin
                nv   = N'($urandom);
                pins = nv;
                edges(D + 4);
                m_rise |= nv & ~m_db & m_en;
                m_fall |= ~nv & m_db & m_en;
                m_db   = nv;
            end else if (op == 2) begin
                mask = N'($urandom) | 24'h1;
                pins = m_db ^ mask;
                edges($urandom_range(1, D - 1));
                pins = m_db;
                edges(D);
            end else if (op == 3) begin
                nv = N'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    wr(8'h84, 32'(nv));
                    m_rise &= ~nv;
                end else begin
                    wr(8'h88, 32'(nv));
                    m_fall &= ~nv;
                end
            end else begin
                nv = N'($urandom);
                wr(8'h8C, {8'hFF, nv});
                m_en = nv;
            end
            check_all($sformatf("rnd%0d", it));
        end

        pins = '0;
        edges(D + 4);
        mmio_addr = B | 32'h80;
        mmio_read = 1'b1;
        #2 rst_n = 1'b0;
        edges(1);
        mmio_read = 1'b0;
        rst_n = 1'b1;
        seen = mmio_done;
        repeat (3) begin
            edges(1);
            seen |= mmio_done;
        end
        chk("rst_drop", {31'b0, seen}, 32'd0);
        m_db = '0;
        m_rise = '0;
        m_fall = '0;
        m_en = '0;
        check_all("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mmio_input_bank.md
# mmio_input_bank

Parametrised successor of the 24-switch MMIO reader: N debounced input pins behind the CPU MMIO handshake, with a packed value register, per-pin rising/falling edge capture into sticky write-1-to-clear pending registers, an edge-enable mask and a level interrupt. Sits on the MMIO bus beside the other peripherals and keeps the legacy one-bit-per-word view at offsets 0x00-0x7F, so existing switch-polling software runs unchanged.

## Interface
- N_PINS, 24: input channel count, 1..32
- BASE_ADDR, 32'hFFFF0000: window base, 256-byte aligned
- DB_CYCLES, 100000: stable cycles required before a pin change is accepted; 0 = debounce bypass
- sys_clk  in  1  the single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mmio_read  in  1  read request, held until mmio_done
- mmio_write  in  1  write request, held until mmio_done
- mmio_addr  in  32  byte address
- mmio_write_data  in  32  write data
- mmio_work  out  1  combinational: address in [BASE_ADDR, BASE_ADDR+0xFF] and (read or write)
- mmio_done  out  1  one-cycle completion pulse
- mmio_read_data  out  32  read data, valid only while mmio_done=1, else 0
- irq  out  1  registered OR of (rise_pend | fall_pend)
- pins  in  N_PINS  raw asynchronous inputs

## Operation
- Register map (offset = addr[7:0], addr[1:0] ignored):
  - 0x00-0x7C word k: {31'b0, db[k]}; k >= N_PINS reads 0
  - 0x80 VALUE (RO): debounced vector, zero-extended
  - 0x84 RISE_PEND (R/W1C), 0x88 FALL_PEND (R/W1C)
  - 0x8C EDGE_EN (RW): bits [N_PINS-1:0] writable, upper bits read 0; reset 0
  - 0x90-0xFC: reserved, read 0, writes ignored
- Writes to RO/reserved offsets complete normally, no effect.
- Per pin: 2-flop synchroniser -> debouncer. Counter clears whenever sync == db; counts while they differ; when it reaches DB_CYCLES-1 with sync still differing, db <= sync and counter clears. DB_CYCLES=0: db <= sync every cycle.
- Edge: db 0->1 with EDGE_EN[k] sets RISE_PEND[k]; 1->0 sets FALL_PEND[k]. Disabled pins never set pending; clearing EDGE_EN does not clear existing pending bits.
- W1C: bits set in mmio_write_data clear pending bits. Same-cycle set and clear of one bit: set wins.
- Handshake: on a cycle with mmio_done=0 and a request in window, next edge mmio_done<=1 and read data is loaded (write takes effect on that same edge). The cycle after done, done<=0 and data<=0 regardless of requests. Write has priority over read if both asserted. Requests outside window are ignored (no done).

## Timing
- Reset (async, all): mmio_done=0, mmio_read_data=0, irq=0, db=0, sync=0, counters=0, RISE/FALL_PEND=0, EDGE_EN=0.
- Access latency: request cycle T -> done at T+1 -> idle at T+2; back-to-back requests complete every 2 cycles.
- Pin latency (DB_CYCLES=D>0, pin held stable): pin change -> sync at +2 edges -> db at +2+D -> pending bit at +3+D -> irq at +4+D.
- Glitch shorter than D sync cycles never reaches db.
- Reset mid-access drops the transaction; no done follows deassertion.

## Structure
- Shared package mmio_pkg: BASE_ADDR default, offset constants OFF_VALUE/OFF_RISE/OFF_FALL/OFF_EN, window size 256.
- Sub-module input_debouncer (sync + counter, counter width $clog2(DB_CYCLES+1), min 1), instantiated N_PINS times via generate.

## Test plan
- Reset, N_PINS=24, DB_CYCLES=4: read 0x80 -> 0, irq=0; read 0xFFFF0100 -> no mmio_done, mmio_work=0.
- pins=24'hA5A5A5 held: VALUE reads 0x00A5A5A5 after 6 edges; word 0x14 (pin 5) reads 1, word 0x7C reads 0.
- Pin 0 pulses high for 3 cycles: VALUE stays 0, RISE_PEND stays 0.
- EDGE_EN=0x1, pin 0 rises then falls: RISE_PEND=1, FALL_PEND=1, irq=1; write 0x84 <- 1 then 0x88 <- 1: both 0, irq=0 next cycle.
- Pin 0 rise debounces on the same edge as W1C of RISE_PEND bit 0: bit stays 1.
- Write 0x8C <- 0xFFFFFFFF with N_PINS=24: reads back 0x00FFFFFF; write 0x80 <- 0x1234: VALUE unchanged, done pulses once.
